mannix_ddr_loader: RTL and testbench

// - DDR-to-memory-farm load engine, directly upstream of the memory-farm demux.
// - Takes a software load command (DDR byte address, byte length) and issues DDR read bursts.
// - Packs the 32-bit DDR read beats into 256-bit SRAM lines.
// - Streams the lines to the farm with valid/ready, plus last-line and valid-byte markers.

---
 rtl/mannix_ddr_loader_pkg.sv | 44 ++++
 rtl/mannix_ddr_loader_if.sv | 40 ++++
 rtl/mannix_ddr_loader_fifo.sv | 53 +++++
 rtl/mannix_ddr_loader.sv | 162 ++++++++++++++++
 tb/tb_mannix_ddr_loader.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mannix_ddr_loader_pkg.sv
// Shared types and helpers for the DDR-to-memory-farm load engine.
// Lines are 32 bytes built from eight 32-bit DDR read beats.
package mannix_ddr_pkg;

   localparam int LINE_BYTES     = 32;
   localparam int BEAT_BYTES     = 4;
   localparam int BEATS_PER_LINE = 8;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      DATA,
      DRAIN,
      FIN
   } ld_state_e;

   typedef struct packed {
      logic [255:0] data;
      logic         last;
      logic [4:0]   nbytes_m1;
   } line_entry_s;

   function automatic logic [4:0] burst_len(
      input logic [17:0] rem,
      input int unsigned mx
   );
      if (rem > 18'(mx)) return 5'(mx);
      return rem[4:0];
   endfunction

   // n is the count of valid low bytes; 0 means all four are valid
   function automatic logic [31:0] mask_beat(
      input logic [31:0] d,
      input logic [1:0]  n
   );
      logic [31:0] m;
      m = d;
      for (int b = 0; b < 4; b++) begin
         if (n != 2'd0 && b >= int'(n)) m[8*b +: 8] = 8'h00;
      end
      return m;
   endfunction

endpackage

// File: rtl/mannix_ddr_loader_if.sv
// Command, DDR read and farm line-stream signals of the load engine.
// slave is the engine side, master is the surrounding system.
interface mannix_ddr_loader_if;

   logic         start;
   logic [31:0]  ddr_base;
   logic [18:0]  len_bytes;
   logic         busy;
   logic         done;
   logic         ddr_rd_req;
   logic [31:0]  ddr_rd_addr;
   logic [4:0]   ddr_rd_beats;
   logic         ddr_rd_gnt;
   logic         ddr_rvalid;
   logic [31:0]  ddr_rdata;
   logic         line_valid;
   logic [255:0] line_data;
   logic         line_last;
   logic [4:0]   line_nbytes_m1;
   logic         line_ready;

   modport slave (
      input  start, ddr_base, len_bytes,
      input  ddr_rd_gnt, ddr_rvalid, ddr_rdata,
      input  line_ready,
      output busy, done,
      output ddr_rd_req, ddr_rd_addr, ddr_rd_beats,
      output line_valid, line_data, line_last, line_nbytes_m1
   );

   modport master (
      output start, ddr_base, len_bytes,
      output ddr_rd_gnt, ddr_rvalid, ddr_rdata,
      output line_ready,
      input  busy, done,
      input  ddr_rd_req, ddr_rd_addr, ddr_rd_beats,
      input  line_valid, line_data, line_last, line_nbytes_m1
   );

endinterface

// File: rtl/mannix_ddr_loader_fifo.sv
// Show-ahead line FIFO: head entry is visible while o_valid is high.
// Push and pop may coincide at any occupancy, including full.
module mem_line_fifo
   import mannix_ddr_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  line_entry_s   i_entry,
   input  logic          i_pop,
   output logic          o_valid,
   output line_entry_s   o_entry,
   output logic [CW-1:0] o_count
);

   line_entry_s   r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_cnt;
   logic          w_pop;
   logic          w_push;

   assign w_pop  = i_pop && (r_cnt != '0);
   assign w_push = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_entry;
            r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
         end
         if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_valid = (r_cnt != '0);
   assign o_entry = r_mem[r_rd];
   assign o_count = r_cnt;

endmodule

// File: rtl/mannix_ddr_loader.sv
// DDR load engine: bursts DDR reads, packs 32-bit beats into 256-bit
// lines and streams them to the memory farm with last/nbytes markers.
module mannix_ddr_loader
   import mannix_ddr_pkg::*;
#(
   parameter int MAX_BURST       = 16,
   parameter int LINE_FIFO_DEPTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   mannix_ddr_loader_if.slave bus
);

   localparam int CW = $clog2(LINE_FIFO_DEPTH + 1);

   ld_state_e     r_state;
   logic          r_busy;
   logic          r_done;
   logic          r_req;
   logic [31:0]   r_addr;
   logic [4:0]    r_beats;
   logic [17:0]   r_req_left;
   logic [17:0]   r_rx_left;
   logic [4:0]    r_burst_left;
   logic [1:0]    r_tail;
   logic [4:0]    r_last_m1;
   logic [255:0]  r_line;
   logic [2:0]    r_beat_idx;

   logic [17:0]   w_total;
   logic          w_final;
   logic          w_line_end;
   logic          w_credit;
   logic [31:0]   w_beat;
   logic [255:0]  w_line;
   logic          w_push;
   logic          w_pop;
   line_entry_s   w_entry;
   line_entry_s   w_head;
   logic          w_fvalid;
   logic [CW-1:0] w_occ;

   assign w_total    = 18'((20'(bus.len_bytes) + 20'd3) >> 2);
   assign w_final    = (r_rx_left == 18'd1);
   assign w_line_end = w_final ||
                       (r_beat_idx == 3'(BEATS_PER_LINE - 1));
   // Leaves room for a whole burst plus the partial line in flight
   assign w_credit   = int'(w_occ) <= LINE_FIFO_DEPTH - 3;
   assign w_push     = (r_state == DATA) && bus.ddr_rvalid && w_line_end;
   assign w_pop      = w_fvalid && bus.line_ready;

   always_comb begin
      w_beat = bus.ddr_rdata;
      if (w_final) w_beat = mask_beat(bus.ddr_rdata, r_tail);
      w_line = r_line;
      w_line[{r_beat_idx, 5'd0} +: 32] = w_beat;
      w_entry.data      = w_line;
      w_entry.last      = w_final;
      w_entry.nbytes_m1 = w_final ? r_last_m1 : 5'd31;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_req        <= 1'b0;
         r_addr       <= '0;
         r_beats      <= '0;
         r_req_left   <= '0;
         r_rx_left    <= '0;
         r_burst_left <= '0;
         r_tail       <= '0;
         r_last_m1    <= '0;
         r_line       <= '0;
         r_beat_idx   <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_busy <= 1'b0;
               if (bus.start && !r_busy) begin
                  r_busy     <= 1'b1;
                  r_addr     <= bus.ddr_base & 32'hFFFF_FFFC;
                  r_req_left <= w_total;
                  r_rx_left  <= w_total;
                  r_tail     <= bus.len_bytes[1:0];
                  r_last_m1  <= 5'((bus.len_bytes - 19'd1) %
                                   19'(LINE_BYTES));
                  r_beats    <= burst_len(w_total, MAX_BURST);
                  r_line     <= '0;
                  r_beat_idx <= '0;
                  r_state    <= (bus.len_bytes == '0) ? FIN : REQ;
               end
            end
            REQ: begin
               if (r_req && bus.ddr_rd_gnt) begin
                  r_req        <= 1'b0;
                  r_addr       <= r_addr +
                                  32'(int'(r_beats) * BEAT_BYTES);
                  r_req_left   <= r_req_left - 18'(r_beats);
                  r_burst_left <= r_beats;
                  r_state      <= DATA;
               end else if (w_credit) begin
                  r_req <= 1'b1;
               end
            end
            DATA: begin
               if (bus.ddr_rvalid) begin
                  r_rx_left    <= r_rx_left - 18'd1;
                  r_burst_left <= r_burst_left - 5'd1;
                  if (w_line_end) begin
                     r_line     <= '0;
                     r_beat_idx <= '0;
                  end else begin
                     r_line     <= w_line;
                     r_beat_idx <= r_beat_idx + 3'd1;
                  end
                  if (w_final) begin
                     r_state <= DRAIN;
                  end else if (r_burst_left == 5'd1) begin
                     r_beats <= burst_len(r_req_left, MAX_BURST);
                     r_state <= REQ;
                  end
               end
            end
            DRAIN: begin
               if (w_occ == '0) r_state <= FIN;
            end
            FIN: begin
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   mem_line_fifo #(
      .DEPTH(LINE_FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_entry (w_entry),
      .i_pop   (w_pop),
      .o_valid (w_fvalid),
      .o_entry (w_head),
      .o_count (w_occ)
   );

   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.ddr_rd_req     = r_req;
   assign bus.ddr_rd_addr    = r_addr;
   assign bus.ddr_rd_beats   = r_beats;
   assign bus.line_valid     = w_fvalid;
   assign bus.line_data      = w_head.data;
   assign bus.line_last      = w_head.last;
   assign bus.line_nbytes_m1 = w_head.nbytes_m1;

endmodule

// File: tb/tb_mannix_ddr_loader.sv
// Directed bench for mannix_ddr_loader with a DDR responder model
// and a line collector; expected lines derive from address and length.
module tb_mannix_ddr_loader;

   localparam logic [31:0] KEY = 32'hC3C3_5A5A;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mannix_ddr_loader_if ifc ();

   mannix_ddr_loader #(
      .MAX_BURST       (16),
      .LINE_FIFO_DEPTH (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   typedef struct {
      logic [255:0] d;
      logic         last;
      logic [4:0]   nb;
   } ln_t;

   int checks = 0;
   int failures = 0;
   int gnt_delay = 0;
   bit ddr_kill = 1'b0;
   int beats_sent = 0;
   int done_cnt = 0;
   int req_cycles = 0;
   ln_t q_line[$];
   logic [31:0] q_addr[$];
   logic [4:0] q_beats[$];

   function automatic logic [255:0] exp_line(
      input logic [31:0] base, input int line, input int len
   );
      logic [255:0] v;
      logic [31:0] w;
      v = '0;
      for (int k = 0; k < 8; k++) begin
         int bi;
         bi = line * 32 + k * 4;
         w = (base + 32'(bi)) ^ KEY;
         for (int j = 0; j < 4; j++)
            if (bi + j >= len) w[8*j +: 8] = 8'h00;
         v[32*k +: 32] = w;
      end
      return v;
   endfunction

   initial begin : gnt_proc
      int wc;
      wc = 0;
      ifc.ddr_rd_gnt = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ifc.ddr_rd_req) begin
            wc++;
            ifc.ddr_rd_gnt = (wc > gnt_delay);
         end else begin
            wc = 0;
            ifc.ddr_rd_gnt = 1'b0;
         end
      end
   end

   initial begin : ddr_proc
      logic [31:0] a;
      int n;
      ifc.ddr_rvalid = 1'b0;
      ifc.ddr_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && ifc.ddr_rd_req && ifc.ddr_rd_gnt) begin
            a = ifc.ddr_rd_addr;
            n = int'(ifc.ddr_rd_beats);
            q_addr.push_back(a);
            q_beats.push_back(ifc.ddr_rd_beats);
            @(posedge clk);
            for (int i = 0; i < n && !ddr_kill; i++) begin
               #1;
               ifc.ddr_rvalid = 1'b1;
               ifc.ddr_rdata = a ^ KEY;
               a = a + 32'd4;
               @(posedge clk);
               beats_sent++;
            end
            #1;
            ifc.ddr_rvalid = 1'b0;
            ifc.ddr_rdata = '0;
         end
      end
   end

   initial begin : mon_proc
      forever begin
         @(negedge clk);
         if (rst_n && ifc.line_valid && ifc.line_ready)
            q_line.push_back('{ifc.line_data, ifc.line_last,
                               ifc.line_nbytes_m1});
         if (rst_n && ifc.done) done_cnt++;
         if (rst_n && ifc.ddr_rd_req) req_cycles++;
      end
   end

   task automatic issue(input logic [31:0] base, input logic [18:0] len);
      @(posedge clk);
      #1;
      ifc.start = 1'b1;
      ifc.ddr_base = base;
      ifc.len_bytes = len;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (ifc.done) ok = 1'b1;
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({ifc.busy, ifc.done, ifc.ddr_rd_req, ifc.line_valid,
           ifc.line_last} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 00000",
                  {ifc.busy, ifc.done, ifc.ddr_rd_req,
                   ifc.line_valid, ifc.line_last});
      end
      checks++;
      if ({ifc.ddr_rd_addr, ifc.ddr_rd_beats, ifc.line_nbytes_m1} !== '0)
      begin
         failures++;
         $display("FAIL reset_addr: got %h/%0d/%0d want 0",
                  ifc.ddr_rd_addr, ifc.ddr_rd_beats, ifc.line_nbytes_m1);
      end
      checks++;
      if (ifc.line_data !== '0) begin
         failures++;
         $display("FAIL reset_data: got %h want 0", ifc.line_data);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int l0 = q_line.size();
      int r0 = q_addr.size();
      int d0 = done_cnt;
      bit ok;
      issue(32'h1000, 19'd64);
      wait_done(200, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL basic_done: got timeout want done");
      end
      checks++;
      if (q_addr.size() - r0 != 1) begin
         failures++;
         $display("FAIL basic_nreq: got %0d want 1", q_addr.size() - r0);
      end else begin
         checks++;
         if ({q_addr[r0], q_beats[r0]} !== {32'h1000, 5'd16}) begin
            failures++;
            $display("FAIL basic_req: got %h/%0d want 1000/16",
                     q_addr[r0], q_beats[r0]);
         end
      end
      checks++;
      if (q_line.size() - l0 != 2) begin
         failures++;
         $display("FAIL basic_nlines: got %0d want 2", q_line.size() - l0);
      end else begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (q_line[l0+k].d !== exp_line(32'h1000, k, 64)) begin
               failures++;
               $display("FAIL basic_data%0d: got %h want %h", k,
                        q_line[l0+k].d, exp_line(32'h1000, k, 64));
            end
            checks++;
            if ({q_line[l0+k].last, q_line[l0+k].nb} !==
                {(k == 1), 5'd31}) begin
               failures++;
               $display("FAIL basic_mark%0d: got %b/%0d want %b/31", k,
                        q_line[l0+k].last, q_line[l0+k].nb, k == 1);
            end
         end
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         failures++;
         $display("FAIL basic_ndone: got %0d want 1", done_cnt - d0);
      end
   endtask

   task automatic test_partial();
      int l0 = q_line.size();
      int r0 = q_addr.size();
      bit ok;
      issue(32'h2002, 19'd37);
      wait_done(200, ok);
      checks++;
      if (!ok || q_addr.size() - r0 != 1) begin
         failures++;
         $display("FAIL part_req: got ok=%0d n=%0d want ok=1 n=1",
                  ok, q_addr.size() - r0);
      end else begin
         checks++;
         if ({q_addr[r0], q_beats[r0]} !== {32'h2000, 5'd10}) begin
            failures++;
            $display("FAIL part_burst: got %h/%0d want 2000/10",
                     q_addr[r0], q_beats[r0]);
         end
      end
      checks++;
      if (q_line.size() - l0 != 2) begin
         failures++;
         $display("FAIL part_nlines: got %0d want 2", q_line.size() - l0);
      end else begin
         checks++;
         if ({q_line[l0].last, q_line[l0].nb} !== {1'b0, 5'd31}) begin
            failures++;
            $display("FAIL part_mark0: got %b/%0d want 0/31",
                     q_line[l0].last, q_line[l0].nb);
         end
         checks++;
         if ({q_line[l0+1].last, q_line[l0+1].nb} !== {1'b1, 5'd4}) begin
            failures++;
            $display("FAIL part_mark1: got %b/%0d want 1/4",
                     q_line[l0+1].last, q_line[l0+1].nb);
         end
         checks++;
         if (q_line[l0+1].d[255:40] !== '0) begin
            failures++;
            $display("FAIL part_zero: got %h want 0",
                     q_line[l0+1].d[255:40]);
         end
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (q_line[l0+k].d !== exp_line(32'h2000, k, 37)) begin
               failures++;
               $display("FAIL part_data%0d: got %h want %h", k,
                        q_line[l0+k].d, exp_line(32'h2000, k, 37));
            end
         end
      end
   endtask

   task automatic test_gnt_delay();
      int l0 = q_line.size();
      bit seen = 1'b0;
      bit ok;
      gnt_delay = 5;
      issue(32'h3000, 19'd32);
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = ifc.ddr_rd_req;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL gnt_req: got no req want req");
      end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({ifc.ddr_rd_req, ifc.ddr_rd_addr, ifc.ddr_rd_beats} !==
             {1'b1, 32'h3000, 5'd8}) begin
            failures++;
            $display("FAIL gnt_stable%0d: got %b/%h/%0d want 1/3000/8", c,
                     ifc.ddr_rd_req, ifc.ddr_rd_addr, ifc.ddr_rd_beats);
         end
         @(negedge clk);
      end
      wait_done(200, ok);
      gnt_delay = 0;
      checks++;
      if (!ok || q_line.size() - l0 != 1) begin
         failures++;
         $display("FAIL gnt_line: got ok=%0d n=%0d want ok=1 n=1",
                  ok, q_line.size() - l0);
      end else begin
         checks++;
         if ({q_line[l0].d, q_line[l0].last} !==
             {exp_line(32'h3000, 0, 32), 1'b1}) begin
            failures++;
            $display("FAIL gnt_data: got %h/%b want %h/1", q_line[l0].d,
                     q_line[l0].last, exp_line(32'h3000, 0, 32));
         end
      end
   endtask

   task automatic test_zero_len();
      int l0 = q_line.size();
      int q0 = req_cycles;
      int d0 = done_cnt;
      @(posedge clk);
      #1;
      ifc.start = 1'b1;
      ifc.ddr_base = 32'h6000;
      ifc.len_bytes = 19'd0;
      @(posedge clk);
      #1;
      checks++;
      if ({ifc.busy, ifc.done} !== 2'b10) begin
         failures++;
         $display("FAIL zero_c1: got busy,done=%b want 10",
                  {ifc.busy, ifc.done});
      end
      ifc.len_bytes = 19'd64;
      @(posedge clk);
      #1;
      checks++;
      if ({ifc.busy, ifc.done} !== 2'b11) begin
         failures++;
         $display("FAIL zero_c2: got busy,done=%b want 11",
                  {ifc.busy, ifc.done});
      end
      ifc.start = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({ifc.busy, ifc.done} !== 2'b00) begin
         failures++;
         $display("FAIL zero_c3: got busy,done=%b want 00",
                  {ifc.busy, ifc.done});
      end
      repeat (20) @(posedge clk);
      checks++;
      if (req_cycles - q0 != 0 || q_line.size() - l0 != 0) begin
         failures++;
         $display("FAIL zero_quiet: got req=%0d lines=%0d want 0/0",
                  req_cycles - q0, q_line.size() - l0);
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         failures++;
         $display("FAIL zero_ndone: got %0d want 1", done_cnt - d0);
      end
   endtask

   task automatic test_backpressure();
      int l0 = q_line.size();
      int r0 = q_addr.size();
      bit ok;
      ifc.line_ready = 1'b0;
      issue(32'h1000, 19'd1024);
      repeat (60) @(negedge clk);
      checks++;
      if (q_addr.size() - r0 != 1 || ifc.ddr_rd_req !== 1'b0) begin
         failures++;
         $display("FAIL bp_stall: got nreq=%0d req=%b want 1/0",
                  q_addr.size() - r0, ifc.ddr_rd_req);
      end
      checks++;
      if ({ifc.line_valid, ifc.busy} !== 2'b11) begin
         failures++;
         $display("FAIL bp_hold: got valid,busy=%b want 11",
                  {ifc.line_valid, ifc.busy});
      end
      @(posedge clk);
      #1;
      ifc.line_ready = 1'b1;
      wait_done(3000, ok);
      checks++;
      if (!ok || q_addr.size() - r0 != 16) begin
         failures++;
         $display("FAIL bp_nreq: got ok=%0d n=%0d want ok=1 n=16",
                  ok, q_addr.size() - r0);
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if ({q_addr[r0+i], q_beats[r0+i]} !==
                {32'h1000 + 32'(i * 64), 5'd16}) begin
               failures++;
               $display("FAIL bp_req%0d: got %h/%0d want %h/16", i,
                        q_addr[r0+i], q_beats[r0+i],
                        32'h1000 + 32'(i * 64));
            end
         end
      end
      checks++;
      if (q_line.size() - l0 != 32) begin
         failures++;
         $display("FAIL bp_nlines: got %0d want 32", q_line.size() - l0);
      end else begin
         for (int k = 0; k < 32; k++) begin
            checks++;
            if ({q_line[l0+k].d, q_line[l0+k].last, q_line[l0+k].nb} !==
                {exp_line(32'h1000, k, 1024), (k == 31), 5'd31}) begin
               failures++;
               $display("FAIL bp_line%0d: got %h/%b/%0d want %h/%b/31", k,
                        q_line[l0+k].d, q_line[l0+k].last, q_line[l0+k].nb,
                        exp_line(32'h1000, k, 1024), k == 31);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int b0 = beats_sent;
      int l0;
      int r0;
      int d0;
      bit hit = 1'b0;
      bit ok;
      issue(32'h4000, 19'd64);
      for (int i = 0; i < 60 && !hit; i++) begin
         @(negedge clk);
         hit = (beats_sent - b0 == 5);
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL rstmid_beats: got %0d want 5", beats_sent - b0);
      end
      rst_n = 1'b0;
      ddr_kill = 1'b1;
      #1;
      checks++;
      if ({ifc.busy, ifc.done, ifc.ddr_rd_req, ifc.line_valid,
           ifc.ddr_rd_addr, ifc.ddr_rd_beats} !== '0) begin
         failures++;
         $display("FAIL rstmid_out: got %b/%h/%0d want 0",
                  {ifc.busy, ifc.done, ifc.ddr_rd_req, ifc.line_valid},
                  ifc.ddr_rd_addr, ifc.ddr_rd_beats);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ddr_kill = 1'b0;
      l0 = q_line.size();
      r0 = q_addr.size();
      d0 = done_cnt;
      issue(32'h5000, 19'd32);
      wait_done(200, ok);
      checks++;
      if (!ok || done_cnt - d0 != 1 || q_addr.size() - r0 != 1) begin
         failures++;
         $display("FAIL rstmid_cmd: got ok=%0d done=%0d req=%0d want 1/1/1",
                  ok, done_cnt - d0, q_addr.size() - r0);
      end
      checks++;
      if (q_line.size() - l0 != 1) begin
         failures++;
         $display("FAIL rstmid_nlines: got %0d want 1", q_line.size() - l0);
      end else begin
         checks++;
         if ({q_line[l0].d, q_line[l0].last, q_line[l0].nb} !==
             {exp_line(32'h5000, 0, 32), 1'b1, 5'd31}) begin
            failures++;
            $display("FAIL rstmid_line: got %h/%b/%0d want %h/1/31",
                     q_line[l0].d, q_line[l0].last, q_line[l0].nb,
                     exp_line(32'h5000, 0, 32));
         end
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      ifc.start = 1'b0;
      ifc.ddr_base = '0;
      ifc.len_bytes = '0;
      ifc.line_ready = 1'b1;
      test_reset();
      test_basic();
      test_partial();
      test_gnt_delay();
      test_zero_len();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
